matrix_result_tx: RTL
=====================

Name: matrix_result_tx

Overview:
- Streams the N×N product matrix out of the result RAM over UART once the multiplier finishes.
- Transmit-side counterpart of the matrix receive path: same 8N1 framing, same b_sel baud selection, same size-first ordering.
- Sits between the multiplier's result RAM (read port) and the top-level tx pin.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; baud divisors are derived from it.
- MAX_N, 10, largest supported matrix dimension.
- RES_W, 24, width of one result element; must be a multiple of 8.
- ADDR_W, 7, result RAM address width; 2^ADDR_W ≥ MAX_N*MAX_N.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- b_sel  in  2  baud select: 00=4800, 01=9600, 10=19200, 11=115200.
- start  in  1  one-cycle pulse; begins transmission of the matrix.
- size  in  8  matrix dimension N, sampled on start.
- rd_addr  out  ADDR_W  result RAM read address, row-major, element (r,c) at r*N+c.
- rd_data  in  RES_W  result RAM data, valid exactly 1 cycle after rd_addr.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the stop bit of the last byte.
- tx  out  1  UART serial output, idle high.

Behaviour:
- Reset values: tx=1, busy=0, done=0, rd_addr=0. All state returns to IDLE immediately, including mid-frame; tx goes high asynchronously with rst.
- Baud divisor per b_sel, rounded to nearest: 10417 / 5208 / 2604 / 434 clocks per bit.
  - b_sel and size are latched on an accepted start.
  - Changes to b_sel or size while busy are ignored.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held for exactly the divisor count. No gap cycles between consecutive frames beyond those listed below.
- Byte order:
  - Header byte = N.
  - Then N*N elements, row-major.
  - Each element is sent as RES_W/8 bytes, most-significant byte first.
- FSM states and transitions:
  - IDLE: wait for start.
    - start with 1 ≤ size ≤ MAX_N: latch size and b_sel, busy=1, element index=0, go to HDR.
    - start with size=0 or size>MAX_N: done pulses the next cycle, busy stays 0, nothing is transmitted.
  - HDR: hand N to the TX core, go to WAIT_HDR.
  - WAIT_HDR: when the core is ready again, go to FETCH.
  - FETCH: drive rd_addr = element index, go to LOAD.
  - LOAD: capture rd_data into the shift register, byte count = RES_W/8, go to SEND.
  - SEND: hand the top byte to the core, shift left by 8, decrement byte count, go to WAIT.
  - WAIT: on core ready:
    - bytes remain → SEND;
    - else element index < N*N-1 → increment index, go to FETCH;
    - else → DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while busy is ignored.
- Element index counter: width ADDR_W; it never wraps because N*N ≤ 2^ADDR_W.
- N*N is computed once at start, registered, 8×8 → 16-bit truncated to ADDR_W.
- Inter-frame gap: at most 3 idle-high clocks between elements (FETCH/LOAD/SEND) and at most 1 clock between bytes of one element.
- Total bytes = 1 + N*N*RES_W/8.

Decomposition:
- Shared package matrix_uart_pkg holds:
  - the baud divisor constants and a function mapping b_sel to divisor;
  - the MAX_N constant;
  - a localparam for bytes per element.
  - The receive path uses the same package.
- Sub-module uart_tx_core:
  - inputs: clk, rst, divisor, data[7:0], valid;
  - outputs: ready, tx.
  - Accepts a byte when valid && ready and drops ready for the full 10-bit frame.
  - ready rises in the cycle after the stop bit's last clock.
- matrix_result_tx holds only the FSM, counters and element shift register.

Test Plan:
- Reset values: hold rst for 5 cycles → tx=1, busy=0, done=0, rd_addr=0; release with no start → tx stays 1 for 10000 cycles.
- Header plus one element: b_sel=11, size=1, RAM[0]=24'h123456 → bytes 01,12,34,56 on tx, each bit exactly 434 clocks; done pulses once; busy low afterwards.
- Full 10×10 matrix: b_sel=01, size=10, RAM[k]=k*3 → 301 bytes, the second element decodes as 00,00,03; rd_addr walks 0..99; measured bit period 5208 clocks.
- Invalid size: size=0 and size=11 → done pulse 1 cycle after start, busy never rises, tx never leaves 1.
- Ignored inputs while busy: second start and a b_sel change mid-transfer → byte count and bit period unchanged from the first start.
- Reset mid-frame: assert rst during bit 4 of element 2 → tx=1 in the same cycle, busy=0; a fresh start with size=2 then transmits the complete 13-byte sequence from the header.

Source files
------------

// File: rtl/matrix_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_uart_pkg
//  Description : Constants and helpers shared by the matrix UART receive and
//                transmit paths. It holds the baud rates, the b_sel to bit
//                divisor mapping, the matrix size limit and the number of
//                bytes per result element.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_uart_pkg;

   localparam int c_MAX_N          = 10;
   localparam int c_RES_W          = 24;
   localparam int c_BYTES_PER_ELEM = c_RES_W / 8;

   // Width of a bit-period counter. It is wide enough for 4800 baud at clock
   // rates well above 1 GHz.
   localparam int c_DIV_W          = 20;

   localparam int c_CLK_FREQ_DEF   = 50_000_000;
   localparam int c_BAUD_4800      = 4800;
   localparam int c_BAUD_9600      = 9600;
   localparam int c_BAUD_19200     = 19200;
   localparam int c_BAUD_115200    = 115200;

   // Returns the clocks per bit for the selected baud rate, rounded to the
   // nearest integer (0.5 rounds up).
   function automatic logic [c_DIV_W-1:0] baud_divisor(input logic [1:0]  sel,
                                                       input int unsigned clk_freq);
      int unsigned baud;
      case (sel)
         2'b00:   baud = c_BAUD_4800;
         2'b01:   baud = c_BAUD_9600;
         2'b10:   baud = c_BAUD_19200;
         default: baud = c_BAUD_115200;
      endcase
      return c_DIV_W'((clk_freq + baud / 2) / baud);
   endfunction

   // Divisors at the default 50 MHz system clock: 10417 / 5208 / 2604 / 434.
   localparam logic [c_DIV_W-1:0] c_DIV_4800   = baud_divisor(2'b00, c_CLK_FREQ_DEF);
   localparam logic [c_DIV_W-1:0] c_DIV_9600   = baud_divisor(2'b01, c_CLK_FREQ_DEF);
   localparam logic [c_DIV_W-1:0] c_DIV_19200  = baud_divisor(2'b10, c_CLK_FREQ_DEF);
   localparam logic [c_DIV_W-1:0] c_DIV_115200 = baud_divisor(2'b11, c_CLK_FREQ_DEF);

endpackage : matrix_uart_pkg
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_core
//  Description : 8N1 UART byte transmitter. A byte is accepted on
//                valid && ready. ready then stays low for the whole 10-bit
//                frame and rises in the cycle after the last clock of the
//                stop bit. Each bit lasts exactly 'divisor' clocks.
//  Ports       : clk, rst (async, active-high)
//                divisor [DIV_W] clocks per bit, must be stable while busy
//                data [8] / valid    byte to send
//                ready               idle, can accept a byte
//                tx                  serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
   import matrix_uart_pkg::*;
#(
   parameter int DIV_W = c_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] divisor,
   input  logic [7:0]       data,
   input  logic             valid,
   output logic             ready,
   output logic             tx
);

   localparam logic [DIV_W-1:0] c_ONE = DIV_W'(1);

   logic             busy_q;
   logic             tx_q;
   logic [DIV_W-1:0] cnt_q;     // clocks left in the current bit, minus one
   logic [3:0]       bits_q;    // bits still to put on the line
   logic [8:0]       shift_q;   // remaining data bits with the stop bit on top

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= 1'b0;
         tx_q    <= 1'b1;
         cnt_q   <= '0;
         bits_q  <= '0;
         shift_q <= '1;
      end else if (!busy_q) begin
         if (valid) begin
            // The start bit goes onto the line in the clock after acceptance.
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            shift_q <= {1'b1, data};
            bits_q  <= 4'd9;
            cnt_q   <= divisor - c_ONE;
         end
      end else if (cnt_q == '0) begin
         if (bits_q == 4'd0) begin
            // The last clock of the stop bit has passed, so the line is idle.
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
         end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b1, shift_q[8:1]};
            bits_q  <= bits_q - 4'd1;
            cnt_q   <= divisor - c_ONE;
         end
      end else begin
         cnt_q <= cnt_q - c_ONE;
      end
   end

   assign ready = ~busy_q;
   assign tx    = tx_q;

endmodule : uart_tx_core
`default_nettype wire

// File: rtl/matrix_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_result_tx
//  Description : Streams the N x N product matrix out of the result RAM over
//                an 8N1 UART. The header byte N is sent first. It is followed
//                by N*N elements in row-major order, and each element is sent
//                most-significant byte first.
//  Ports       : clk, rst (async, active-high)
//                b_sel [2]        baud select (latched on start)
//                start / size [8] begin a transfer of an N x N matrix
//                rd_addr / rd_data result RAM read port (1-cycle latency)
//                busy / done      transfer in progress / completion pulse
//                tx               serial output, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_tx
   import matrix_uart_pkg::*;
#(
   parameter int CLK_FREQ = c_CLK_FREQ_DEF,
   parameter int MAX_N    = c_MAX_N,
   parameter int RES_W    = c_RES_W,
   parameter int ADDR_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        b_sel,
   input  logic              start,
   input  logic [7:0]        size,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [RES_W-1:0]  rd_data,
   output logic              busy,
   output logic              done,
   output logic              tx
);

   localparam int                c_BYTES    = RES_W / 8;
   localparam int                c_BC_W     = $clog2(c_BYTES + 1);
   localparam logic [c_BC_W-1:0] c_BC_FULL  = c_BC_W'(c_BYTES);
   localparam logic [c_BC_W-1:0] c_BC_ONE   = c_BC_W'(1);
   localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
   localparam logic [7:0]        c_MAX_N8   = 8'(MAX_N);

   localparam logic [2:0] c_ST_IDLE     = 3'd0;
   localparam logic [2:0] c_ST_HDR      = 3'd1;
   localparam logic [2:0] c_ST_WAIT_HDR = 3'd2;
   localparam logic [2:0] c_ST_FETCH    = 3'd3;
   localparam logic [2:0] c_ST_LOAD     = 3'd4;
   localparam logic [2:0] c_ST_SEND     = 3'd5;
   localparam logic [2:0] c_ST_WAIT     = 3'd6;
   localparam logic [2:0] c_ST_DONE     = 3'd7;

   logic [2:0]         state_q, state_d;
   logic [7:0]         n_q;        // latched matrix dimension (header byte)
   logic [ADDR_W-1:0]  nn_q;       // N*N, truncated to the address width
   logic [c_DIV_W-1:0] div_q;      // latched clocks per bit
   logic [ADDR_W-1:0]  idx_q;      // current element index
   logic [RES_W-1:0]   elem_q;     // element shift register, MSB byte on top
   logic [c_BC_W-1:0]  bytes_q;    // bytes of elem_q not yet handed over

   logic              w_size_ok;
   logic [ADDR_W-1:0] w_last_idx;
   logic              w_core_ready;
   logic              w_core_valid;
   logic [7:0]        w_core_data;

   assign w_size_ok  = (size != 8'd0) && (size <= c_MAX_N8);
   // If N*N equals 2^ADDR_W it truncates to zero, and the subtraction wraps
   // to the correct all-ones last index.
   assign w_last_idx = nn_q - c_ADDR_ONE;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= c_ST_IDLE;
      else     state_q <= state_d;
   end

   // The next element is fetched and loaded while the previous byte is still
   // on the line. SEND then holds valid until the core frees up, so the only
   // idle-high clock between frames is the core's own ready cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE:     if (start) state_d = w_size_ok ? c_ST_HDR : c_ST_DONE;
         c_ST_HDR:      if (w_core_ready) state_d = c_ST_WAIT_HDR;
         c_ST_WAIT_HDR: state_d = c_ST_FETCH;
         c_ST_FETCH:    state_d = c_ST_LOAD;
         c_ST_LOAD:     state_d = c_ST_SEND;
         c_ST_SEND:     if (w_core_ready) state_d = c_ST_WAIT;
         c_ST_WAIT: begin
            if (bytes_q != '0)             state_d = c_ST_SEND;
            else if (idx_q != w_last_idx)  state_d = c_ST_FETCH;
            else if (w_core_ready)         state_d = c_ST_DONE;
         end
         c_ST_DONE:     state_d = c_ST_IDLE;
         default:       state_d = c_ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      busy         = (state_q != c_ST_IDLE) && (state_q != c_ST_DONE);
      done         = (state_q == c_ST_DONE);
      w_core_valid = (state_q == c_ST_HDR) || (state_q == c_ST_SEND);
      w_core_data  = (state_q == c_ST_HDR) ? n_q : elem_q[RES_W-1 -: 8];
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q     <= '0;
         nn_q    <= '0;
         div_q   <= '0;
         idx_q   <= '0;
         elem_q  <= '0;
         bytes_q <= '0;
      end else begin
         case (state_q)
            c_ST_IDLE: begin
               if (start && w_size_ok) begin
                  n_q   <= size;
                  nn_q  <= ADDR_W'({8'd0, size} * {8'd0, size});
                  div_q <= baud_divisor(b_sel, CLK_FREQ);
                  idx_q <= '0;
               end
            end
            c_ST_LOAD: begin
               elem_q  <= rd_data;
               bytes_q <= c_BC_FULL;
            end
            c_ST_SEND: begin
               if (w_core_ready) begin
                  elem_q  <= elem_q << 8;
                  bytes_q <= bytes_q - c_BC_ONE;
               end
            end
            c_ST_WAIT: begin
               if (bytes_q == '0 && idx_q != w_last_idx) idx_q <= idx_q + c_ADDR_ONE;
            end
            default: ;
         endcase
      end
   end

   // idx_q is already valid during FETCH, so the RAM returns the element in
   // the LOAD cycle.
   assign rd_addr = idx_q;

   uart_tx_core #(
      .DIV_W (c_DIV_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .divisor (div_q),
      .data    (w_core_data),
      .valid   (w_core_valid),
      .ready   (w_core_ready),
      .tx      (tx)
   );

endmodule : matrix_result_tx
`default_nettype wire
